// File: rtl/cic_comp_fir_if.sv
// Sample-stream and coefficient-port bundle for the CIC compensation FIR.
// The slave modport is the filter side; the master modport is the driving side.
interface cic_comp_fir_if #(
    parameter int NUM_TAPS   = 16,
    parameter int NUM_BITS   = 16,
    parameter int COEFF_BITS = 16
);
    localparam int ADDR_W = $clog2(NUM_TAPS);

    logic                         tick_i;
    logic signed [NUM_BITS-1:0]   signal_i;
    logic                         coeff_we_i;
    logic        [ADDR_W-1:0]     coeff_addr_i;
    logic signed [COEFF_BITS-1:0] coeff_data_i;
    logic signed [NUM_BITS-1:0]   signal_o;
    logic                         tick_o;
    logic                         busy_o;
    logic                         overrun_o;

    modport master (
        output tick_i, signal_i, coeff_we_i, coeff_addr_i, coeff_data_i,
        input  signal_o, tick_o, busy_o, overrun_o
    );

    modport slave (
        input  tick_i, signal_i, coeff_we_i, coeff_addr_i, coeff_data_i,
        output signal_o, tick_o, busy_o, overrun_o
    );
endinterface

// File: rtl/cic_comp_fir.sv
// Decimating compensation FIR behind a CIC: circular sample buffer, one serial
// MAC per output, rounding + saturation to the input width.
module cic_comp_fir #(
    parameter int NUM_TAPS   = 16,
    parameter int DECIMATION = 2,
    parameter int NUM_BITS   = 16,
    parameter int COEFF_BITS = 16
) (
    input logic          clk_i,
    input logic          reset_ni,
    cic_comp_fir_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int BUF    = 2 ** $clog2(NUM_TAPS + DECIMATION);
    localparam int PTR_W  = $clog2(BUF);
    localparam int PH_W   = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int PROD_W = NUM_BITS + COEFF_BITS;
    localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);

    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2 ** (NUM_BITS - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2 ** (NUM_BITS - 1)));
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (COEFF_BITS - 2));

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   rst_sync;
    logic                         rst_n;
    logic [PH_W-1:0]              phase;
    logic                         trigger, busy, last_tap;
    logic [PTR_W-1:0]             wr_ptr, base_ptr, rd_ptr;
    logic [ADDR_W-1:0]            tap;
    logic signed [NUM_BITS-1:0]   sample_buf [BUF];
    logic signed [COEFF_BITS-1:0] coeff_mem  [NUM_TAPS];
    logic signed [NUM_BITS-1:0]   sample;
    logic signed [COEFF_BITS-1:0] coeff;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      acc, acc_sum, rounded, shifted;
    logic signed [NUM_BITS-1:0]   sat_val, signal_q;
    logic                         overrun_q;
    logic                         addr_ok;

    // Assertion is immediate; release is re-timed to clk_i through two flops.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign busy     = (state_q != S_IDLE);
    assign trigger  = bus.tick_i && (phase == PH_W'(DECIMATION - 1));
    assign last_tap = (tap == ADDR_W'(NUM_TAPS - 1));
    assign addr_ok  = (32'(bus.coeff_addr_i) < NUM_TAPS);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)            phase <= '0;
        else if (bus.tick_i)   phase <= trigger ? '0 : phase + 1'b1;
    end

    // NOTE: the sample buffer is reset explicitly because stale samples would leak into the first outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF; i++) sample_buf[i] <= '0;
            wr_ptr <= '0;
        end else if (bus.tick_i) begin
            sample_buf[wr_ptr] <= bus.signal_i;
            wr_ptr             <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            coeff_mem[0] <= COEFF_BITS'((2 ** (COEFF_BITS - 1)) - 1);
            for (int i = 1; i < NUM_TAPS; i++) coeff_mem[i] <= '0;
        end else if (bus.coeff_we_i && !busy && addr_ok) begin
            coeff_mem[bus.coeff_addr_i] <= bus.coeff_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trigger)  state_d = S_MAC;
            S_MAC:   if (last_tap) state_d = S_OUT;
            S_OUT:                 state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o    = busy;
        bus.tick_o    = (state_q == S_OUT);
        bus.signal_o  = signal_q;
        bus.overrun_o = overrun_q;
    end

    // The window is anchored at the trigger sample, so later writes land ahead of it.
    assign rd_ptr  = base_ptr - PTR_W'(tap);
    assign sample  = sample_buf[rd_ptr];
    assign coeff   = coeff_mem[tap];
    assign prod    = PROD_W'(sample) * PROD_W'(coeff);
    assign acc_sum = acc + ACC_W'(prod);
    assign rounded = acc_sum + RND_HALF;
    assign shifted = rounded >>> (COEFF_BITS - 1);

    always_comb begin
        sat_val = shifted[NUM_BITS-1:0];
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[NUM_BITS-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[NUM_BITS-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tap       <= '0;
            base_ptr  <= '0;
            acc       <= '0;
            signal_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (state_q == S_MAC) tap <= tap + 1'b1;
            else                  tap <= '0;
            if (trigger && !busy) begin
                base_ptr <= wr_ptr;
                acc      <= '0;
            end else if (state_q == S_MAC) begin
                acc <= acc_sum;
            end
            // The final product is folded straight into the registered output.
            if (state_q == S_MAC && last_tap) signal_q <= sat_val;
            if (trigger && busy) overrun_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: stimulus pushes expected outputs (value and
// arrival cycle) into a queue; a negedge monitor pops and compares on tick_o.
module tb_cic_comp_fir;
    localparam int LATENCY = 17;

    typedef struct {
        int value;
        int cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    cic_comp_fir_if bus ();

    cic_comp_fir dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.tick_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick_o", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("signal_o", int'(bus.signal_o), e.value);
                check("tick_o_cycle", cyc, e.cycle);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller sits #1 after an edge; the sample is taken at the next edge.
    task automatic tick(input int x, input bit push, input int expv);
        bus.tick_i   = 1'b1;
        bus.signal_i = 16'(x);
        if (push) exp_q.push_back('{expv, cyc + LATENCY});
        @(posedge clk);
        #1;
        bus.tick_i = 1'b0;
    endtask

    task automatic coeff_write(input int addr, input int data);
        bus.coeff_we_i   = 1'b1;
        bus.coeff_addr_i = 4'(addr);
        bus.coeff_data_i = 16'(data);
        @(posedge clk);
        #1;
        bus.coeff_we_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        idle(3);
        reset_ni = 1'b1;
        idle(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.tick_i       = 1'b0;
        bus.signal_i     = '0;
        bus.coeff_we_i   = 1'b0;
        bus.coeff_addr_i = '0;
        bus.coeff_data_i = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state, then default pass-through taps
        check("rst_signal_o", int'(bus.signal_o), 0);
        check("rst_tick_o", int'(bus.tick_o), 0);
        check("rst_busy_o", int'(bus.busy_o), 0);
        check("rst_overrun_o", int'(bus.overrun_o), 0);
        for (int i = 0; i < 6; i++) begin
            tick(16384, (i % 2) == 1, 16384);
            idle(19);
        end
        // Trigger landing on the cycle the FSM returns to idle
        tick(16384, 0, 0);
        tick(16384, 1, 16384);
        check("busy_in_mac", int'(bus.busy_o), 1);
        idle(16);
        tick(16384, 0, 0);
        tick(16384, 1, 16384);
        idle(25);
        check("no_overrun_back_to_back", int'(bus.overrun_o), 0);

        // Positive saturation
        do_reset();
        for (int k = 0; k < 16; k++) coeff_write(k, 32767);
        for (int i = 0; i < 18; i++) begin
            tick(32767, (i % 2) == 1, 32767);
            idle(19);
        end
        // Negative saturation
        do_reset();
        for (int k = 0; k < 16; k++) coeff_write(k, 32767);
        for (int i = 0; i < 18; i++) begin
            tick(-32768, (i % 2) == 1, -32768);
            idle(19);
        end

        // Impulse through tap 3 at half gain
        do_reset();
        coeff_write(0, 0);
        coeff_write(3, 16384);
        tick(0, 0, 0);     idle(19);
        tick(0, 1, 0);     idle(19);
        tick(1000, 0, 0);  idle(19);
        tick(0, 1, 0);     idle(19);
        tick(0, 0, 0);     idle(19);
        tick(0, 1, 500);   idle(19);
        tick(0, 0, 0);     idle(19);
        tick(0, 1, 0);     idle(19);

        // tick_i every cycle: second trigger falls inside MAC
        do_reset();
        tick(16384, 0, 0);
        tick(16384, 1, 16384);
        tick(16384, 0, 0);
        tick(16384, 0, 0);
        check("overrun_set", int'(bus.overrun_o), 1);
        idle(30);
        check("overrun_sticky", int'(bus.overrun_o), 1);

        // Reset in the middle of MAC
        do_reset();
        tick(100, 0, 0);
        tick(100, 1, 100);
        idle(20);
        tick(200, 0, 0);
        tick(200, 0, 0);
        idle(5);
        reset_ni = 1'b0;
        #1;
        check("midmac_signal_o", int'(bus.signal_o), 0);
        check("midmac_busy_o", int'(bus.busy_o), 0);
        check("midmac_tick_o", int'(bus.tick_o), 0);
        idle(3);
        reset_ni = 1'b1;
        idle(40);
        check("post_abort_busy", int'(bus.busy_o), 0);
        tick(300, 0, 0);
        tick(300, 1, 300);
        idle(25);

        // Coefficient write ignored while busy, honoured in idle
        do_reset();
        tick(1000, 0, 0);
        tick(1000, 1, 1000);
        coeff_write(0, 16384);
        idle(25);
        tick(1000, 0, 0);
        tick(1000, 1, 1000);
        idle(25);
        coeff_write(0, 16384);
        tick(1000, 0, 0);
        tick(1000, 1, 500);
        idle(30);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 SHALL have parameter NUM_TAPS, 16, number of FIR taps (>=2).
REQ-002 SHALL have parameter DECIMATION, 2, output decimation factor (>=1).
REQ-003 SHALL have parameter NUM_BITS, 16, signed sample width (input and output).
REQ-004 SHALL have parameter COEFF_BITS, 16, signed Q1.(COEFF_BITS-1) coefficient width.
REQ-005 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port tick_i  input  1  one-cycle input-sample strobe (driven by CIC decimator tick_reduced_o).
REQ-008 SHALL have port signal_i  input  NUM_BITS  signed input sample, valid when tick_i=1.
REQ-009 SHALL have port coeff_we_i  input  1  coefficient write strobe.
REQ-010 SHALL have port coeff_addr_i  input  clog2(NUM_TAPS)  tap index of write.
REQ-011 SHALL have port coeff_data_i  input  COEFF_BITS  signed coefficient value.
REQ-012 SHALL have port signal_o  output  NUM_BITS  signed filtered sample, held until next output.
REQ-013 SHALL have port tick_o  output  1  one-cycle pulse when signal_o updates.
REQ-014 SHALL have port busy_o  output  1  high while MAC sequence in progress.
REQ-015 SHALL have port overrun_o  output  1  sticky flag: an output trigger was dropped.

Function
REQ-016 SHALL store each sample with tick_i=1 into a circular buffer of depth BUF = next power of 2 >= NUM_TAPS+DECIMATION; write pointer increments mod BUF.
REQ-017 SHALL keep phase counter 0..DECIMATION-1, advanced on tick_i, wrapping to 0; a tick_i with phase=DECIMATION-1 is a trigger.
REQ-018 SHALL implement FSM IDLE -> MAC -> OUT -> IDLE; trigger in IDLE moves to MAC next cycle.
REQ-019 MAC SHALL take exactly NUM_TAPS cycles, one multiply-accumulate per cycle: acc = sum c[k]*x[n-k], k=0..NUM_TAPS-1, x[n] = triggering sample.
REQ-020 Read addresses SHALL be (trigger write address - k) mod BUF; samples written during MAC SHALL NOT alter the window.
REQ-021 Product width SHALL be NUM_BITS+COEFF_BITS; acc width NUM_BITS+COEFF_BITS+clog2(NUM_TAPS); no internal wrap.
REQ-022 OUT SHALL compute (acc + 2^(COEFF_BITS-2)) >>> (COEFF_BITS-1), saturate to [-2^(NUM_BITS-1), 2^(NUM_BITS-1)-1], register to signal_o, pulse tick_o one cycle.
REQ-023 tick_o SHALL assert exactly NUM_TAPS+1 cycles after the triggering tick_i cycle.
REQ-024 busy_o SHALL be high in MAC and OUT, low in IDLE.
REQ-025 Trigger while busy_o=1 SHALL be dropped (sample still stored, phase still wraps) and SHALL set overrun_o until reset.
REQ-026 Trigger in the cycle FSM returns to IDLE (busy_o=0) SHALL be accepted normally.
REQ-027 coeff_we_i with busy_o=0 SHALL write c[coeff_addr_i] at the clock edge; with busy_o=1 the write SHALL be ignored.
REQ-028 coeff_addr_i >= NUM_TAPS SHALL be ignored.
REQ-029 With DECIMATION=1 every tick_i SHALL be a trigger.

Reset
REQ-030 reset_ni=0 SHALL immediately clear buffer, pointers, phase, acc, FSM to IDLE, signal_o=0, tick_o=0, busy_o=0, overrun_o=0.
REQ-031 Reset SHALL set c[0]=2^(COEFF_BITS-1)-1, all other taps 0 (pass-through decimator).
REQ-032 Reset asserted mid-MAC SHALL abort; no tick_o for that trigger after release.
REQ-033 Reset deassertion SHALL be synchronized so the first active edge is glitch-free.

Verification (defaults)
REQ-034 Default coeffs, tick_i every 20 cycles, signal_i=16384 -> tick_o every 2nd tick, 17 cycles after it, signal_o=16384.
REQ-035 All 16 coeffs=32767, constant 32767 input -> signal_o=32767; constant -32768 -> signal_o=-32768 (saturation).
REQ-036 Coeffs c[3]=16384 others 0, single impulse 1000 then zeros -> signal_o=500 on output covering n-3, 0 elsewhere.
REQ-037 tick_i every cycle -> second trigger lands in MAC, dropped, overrun_o=1 and stays 1.
REQ-038 reset_ni low 5 cycles into MAC -> outputs 0 at once; no tick_o after release; next trigger filters normally.
REQ-039 coeff_we_i during busy_o=1 -> coefficient unchanged; same write in IDLE -> takes effect next output.
